// File: rtl/lmfe_ctrl.sv
// Sequencer for the 49-entry insert/delete median engine: serpentine 7x7 window scan,
// engine fill at frame start, drain back to all-255 at frame end.
module lmfe_ctrl #(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64,
    parameter int unsigned AW    = 12
) (
    input  logic          clk,
    input  logic          RST_N,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          img_rd,
    output logic [AW-1:0] img_addr,
    input  logic [7:0]    img_data,
    output logic          SEN,
    output logic [7:0]    INS,
    output logic [7:0]    DEL,
    input  logic [7:0]    MED,
    output logic          res_we,
    output logic [AW-1:0] res_addr,
    output logic [7:0]    res_data
);
    // Signed coordinate width: room for -4 .. IMG_W+3
    localparam int unsigned CW = AW + 3;
    localparam logic signed [CW-1:0] C3 = CW'(3);
    localparam logic signed [CW-1:0] C4 = CW'(4);
    localparam logic signed [CW-1:0] WS = CW'(IMG_W);
    localparam logic signed [CW-1:0] HS = CW'(IMG_H);
    localparam logic [AW-1:0] WA   = AW'(IMG_W);
    localparam logic [AW-1:0] XMAX = AW'(IMG_W - 1);
    localparam logic [AW-1:0] YMAX = AW'(IMG_H - 1);

    typedef enum logic [2:0] {StIdle, StFill, StEmit, StMoveH, StMoveV, StDrain, StDone} state_e;

    state_e        state_q, state_d;
    logic          phase_q, phase_d;   // 0: delete-read cycle, 1: insert-read cycle
    logic [2:0]    sc_q, sc_d;         // slot column / move index / wait counter
    logic [2:0]    sr_q, sr_d;         // slot row (fill and drain)
    logic [AW-1:0] cx_q, cx_d, cy_q, cy_d;

    logic          rd_q;               // img_data is valid this cycle
    logic [7:0]    del_cap_q, ins_dflt_q;
    logic          p1_q;               // insert data arrives this cycle; update next cycle
    logic          sen_q;
    logic [7:0]    ins_q, del_q;

    logic                 slot_st, rd_req, in_range;
    logic signed [CW-1:0] cxs, cys, scs, srs, rx, ry;

    assign slot_st = (state_q == StFill) || (state_q == StMoveH) ||
                     (state_q == StMoveV) || (state_q == StDrain);
    assign cxs = $signed({3'b000, cx_q});
    assign cys = $signed({3'b000, cy_q});
    assign scs = $signed({{(CW-3){1'b0}}, sc_q});
    assign srs = $signed({{(CW-3){1'b0}}, sr_q});

    // Coordinate of the pixel addressed in the current read cycle
    always_comb begin
        rx     = cxs - C3 + scs;
        ry     = cys - C3 + srs;
        rd_req = 1'b0;
        case (state_q)
            StFill:  rd_req = phase_q;
            StDrain: rd_req = !phase_q;
            StMoveH: begin
                rd_req = 1'b1;
                ry     = cys - C3 + scs;
                case ({cy_q[0], phase_q})
                    2'b00:   rx = cxs - C3;
                    2'b01:   rx = cxs + C4;
                    2'b10:   rx = cxs + C3;
                    default: rx = cxs - C4;
                endcase
            end
            StMoveV: begin
                rd_req = 1'b1;
                rx     = cxs - C3 + scs;
                ry     = phase_q ? (cys + C4) : (cys - C3);
            end
            default: rd_req = 1'b0;
        endcase
    end

    assign in_range = !rx[CW-1] && (rx < WS) && !ry[CW-1] && (ry < HS);
    assign img_rd   = rd_req && in_range;
    assign img_addr = img_rd ? (ry[AW-1:0] * WA + rx[AW-1:0]) : '0;

    assign done     = (state_q == StDone) && (sc_q == 3'd3);
    assign busy     = (state_q != StIdle) && !done;
    assign res_we   = (state_q == StEmit) && (sc_q == 3'd2);
    assign res_addr = res_we ? (cy_q * WA + cx_q) : '0;
    assign res_data = MED;
    assign SEN      = sen_q;
    assign INS      = ins_q;
    assign DEL      = del_q;

    // Next-state: slot sequencing, window moves, emit and done waits
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        sc_d    = sc_q;
        sr_d    = sr_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFill;
                    phase_d = 1'b0;
                    sc_d    = '0;
                    sr_d    = '0;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            StFill, StDrain: begin
                phase_d = !phase_q;
                if (phase_q) begin
                    if (sc_q == 3'd6) begin
                        sc_d = '0;
                        if (sr_q == 3'd6) begin
                            sr_d    = '0;
                            state_d = (state_q == StFill) ? StEmit : StDone;
                        end else begin
                            sr_d = sr_q + 3'd1;
                        end
                    end else begin
                        sc_d = sc_q + 3'd1;
                    end
                end
            end
            StMoveH, StMoveV: begin
                phase_d = !phase_q;
                if (phase_q) begin
                    if (sc_q == 3'd6) begin
                        sc_d    = '0;
                        state_d = StEmit;
                        if (state_q == StMoveV) cy_d = cy_q + 1'b1;
                        else if (cy_q[0])       cx_d = cx_q - 1'b1;
                        else                    cx_d = cx_q + 1'b1;
                    end else begin
                        sc_d = sc_q + 3'd1;
                    end
                end
            end
            StEmit: begin
                // Wait for the window's last update to land in the engine, then write
                if (sc_q == 3'd2) begin
                    sc_d = '0;
                    if ((!cy_q[0] && (cx_q < XMAX)) || (cy_q[0] && (cx_q != '0))) begin
                        state_d = StMoveH;
                    end else if (cy_q < YMAX) begin
                        state_d = StMoveV;
                    end else begin
                        state_d = StDrain;
                    end
                end else begin
                    sc_d = sc_q + 3'd1;
                end
            end
            StDone: begin
                if (sc_q == 3'd3) begin
                    sc_d    = '0;
                    state_d = StIdle;
                end else begin
                    sc_d = sc_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            phase_q <= 1'b0;
            sc_q    <= '0;
            sr_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            sc_q    <= sc_d;
            sr_q    <= sr_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
        end
    end

    // Pixel capture and engine update pipeline (update 3 cycles after slot start)
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            rd_q       <= 1'b0;
            del_cap_q  <= 8'hFF;
            ins_dflt_q <= 8'h00;
            p1_q       <= 1'b0;
            sen_q      <= 1'b1;
            ins_q      <= 8'hFF;
            del_q      <= 8'hFF;
        end else begin
            rd_q <= img_rd;
            p1_q <= slot_st && phase_q;
            if (slot_st && phase_q) begin
                // Missing delete: 255 in fill (engine starts all-255), 0 when off-image
                del_cap_q  <= rd_q ? img_data : ((state_q == StFill) ? 8'hFF : 8'h00);
                ins_dflt_q <= (state_q == StDrain) ? 8'hFF : 8'h00;
            end
            sen_q <= !p1_q;
            ins_q <= p1_q ? (rd_q ? img_data : ins_dflt_q) : 8'hFF;
            del_q <= p1_q ? del_cap_q : 8'hFF;
        end
    end

endmodule

// File: doc/lmfe_ctrl.md
# lmfe_ctrl

Sequencing controller for the 49-entry insert/delete median engine in the local median filter. It scans a 7×7 window over an image held in external single-port SRAM using a serpentine path. For each move it streams matched insert/delete pixel pairs into the engine and writes the resulting median to a result memory. It also fills the engine at frame start and drains it back to all-255 at frame end, so the engine can be reused frame to frame without a reset.

## Interface
- IMG_W, 64: image width in pixels (≥ 1)
- IMG_H, 64: image height in pixels (≥ 1)
- AW, 12: address width; must satisfy 2^AW ≥ IMG_W*IMG_H
- clk  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low. The top level ties the engine reset to !RST_N.
- start  in  1  one-cycle frame start request; ignored while busy=1
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the frame is complete
- img_rd  out  1  image read strobe
- img_addr  out  AW  image read address = y*IMG_W + x
- img_data  in  8  read data; valid in the cycle after img_rd
- SEN  out  1  engine hold; 1 means no update
- INS  out  8  engine insert value
- DEL  out  8  engine delete value
- MED  in  8  engine median output
- res_we  out  1  result write strobe
- res_addr  out  AW  result address = cy*IMG_W + cx
- res_data  out  8  result value; driven directly from MED

## Operation
- The window is centred at (cx, cy) and covers x in cx-3..cx+3 and y in cy-3..cy+3.
- Any coordinate outside 0..IMG_W-1 / 0..IMG_H-1 reads as pixel value 0. No img_rd is issued for such a coordinate, but it still occupies its slot.
- States:
  - IDLE → FILL on start.
  - FILL: 49 slots, window (0,0); each slot inserts one pixel with DEL=255.
  - EMIT: write the median.
  - After EMIT, go to MOVE_H if a horizontal step remains in the row. Go to MOVE_V at the row end if cy < IMG_H-1. Otherwise go to DRAIN.
  - MOVE_H: 7 slots. Even rows scan left-to-right: delete column cx-3, insert column cx+4, then cx++. Odd rows scan right-to-left: delete column cx+3, insert column cx-4, then cx--.
  - MOVE_V: 7 slots. Delete row cy-3, insert row cy+4, then cy++, cx unchanged.
  - MOVE_H and MOVE_V both return to EMIT.
  - DRAIN: 49 slots; each deletes one final-window pixel with INS=255.
  - DONE: pulse done for one cycle → IDLE.
- Slot rows are taken in order y = cy-3..cy+3; slot columns in order x = cx-3..cx+3.
- Each slot is exactly 2 cycles.
  - Cycle 0: img_rd for the delete pixel (MOVE/DRAIN).
  - Cycle 1: img_rd for the insert pixel (FILL/MOVE).
  - The update is issued (SEN=0 for exactly one cycle) in the cycle after the insert pixel's read data returns, overlapping the next slot's cycle 0 or 1.
  - At all other times SEN=1 and INS=DEL=255.
  - Unused read cycles (FILL delete, DRAIN insert, out-of-range) keep img_rd=0.
- EMIT: res_we=1 for one cycle, exactly in the cycle after the window's last SEN=0 cycle. res_addr is the window centre.
- Pairs with INS==DEL are legal and are engine no-ops; they are issued normally.

## Timing
- Reset values: busy=0, done=0, SEN=1, INS=255, DEL=255, img_rd=0, img_addr=0, res_we=0, res_addr=0; state=IDLE.
- Reset asserted mid-frame returns all outputs to reset values immediately (asynchronously). The frame is abandoned; the engine is reset in parallel.
- Total SEN=0 cycles per frame = 49 + 7*(IMG_W*IMG_H-1) + 49.
- Consecutive SEN=0 cycles within a FILL/MOVE/DRAIN phase are exactly 2 cycles apart.
- res_we pulses exactly IMG_W*IMG_H times per frame. Each address is written once, in serpentine order.
- done rises at least 2 cycles after the last DRAIN update. busy falls in the same cycle done is asserted.
- IMG_W=1 or IMG_H=1: MOVE_H or MOVE_V, respectively, never occurs; the rest of the sequence is unchanged.

## Test plan
- Reset and idle: hold RST_N=0, then release. Required: SEN=1, INS=DEL=255, no img_rd, no res_we for 20 cycles. Then pulse start: busy=1 on the next cycle.
- Constant image, IMG_W=IMG_H=8, all pixels 100. Required: result(0,0)=0, result(0,3)=100, result(3,3)=100. After done, MED=255.
- Ramp image, 8×8, pixel = x + 8*y, checked against a golden zero-padded 7×7 median model. Required:
  - all 64 results match;
  - result addresses follow the order 0..7, 15..8, 16..23, …;
  - each address is written once;
  - exactly 539 SEN=0 cycles in the frame.
- Start pulses during busy on a 8×8 frame are ignored. Required: still exactly 64 writes, and one done pulse per accepted start.
- RST_N pulsed low 200 cycles into a frame. Required:
  - outputs at reset values while RST_N is low;
  - after release and a new start, the full ramp frame result is correct.
- Degenerate 1×5 and 5×1 images, pixels 1..5. Required: all results 0, since at most 5 of 49 window entries are nonzero. Exactly 5 writes; done pulses.
